// File: rtl/pdm_sigma_delta_tx_pkg.sv
// pdm_pkg: shared constants, types and the integrator saturation helper for
// the PCM-to-PDM transmitter.
//   DEF_*      default widths / oversampling ratio of the transmitter
//   FS         PDM full scale for the default PCM width (2^(DATA_W-1))
//   SAT_MAX/MIN integrator clamp limits for the default integrator width
//   LOG2_OSR   interpolation shift for the default oversampling ratio
//   sat_acc()  clamps a wide signed value to +/-(2^(acc_w-1)-1)
package pdm_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_OSR    = 64;
    localparam int DEF_ACC_W  = 24;

    localparam int     LOG2_OSR = $clog2(DEF_OSR);
    localparam longint FS       = longint'(1) <<< (DEF_DATA_W - 1);
    localparam longint SAT_MAX  = (longint'(1) <<< (DEF_ACC_W - 1)) - 1;
    localparam longint SAT_MIN  = -SAT_MAX;

    typedef logic signed [DEF_DATA_W-1:0] pcm_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;

    // Symmetric clamp so the integrators never wrap around.
    function automatic logic signed [63:0] sat_acc(input logic signed [63:0] v,
                                                   input int                 acc_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo = -hi;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/pdm_sigma_delta_tx_sd2_core.sv
// pdm_sd2_core: second-order sigma-delta loop producing the 1-bit PDM stream.
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   tick       advance the loop by one PDM bit
//   x          interpolated signed input (DATA_W bits)
//   pdm_out    PDM bit, 1 = +FS, 0 = -FS
//   i1, i2     integrator states (exported for debug)
module pdm_sd2_core
    import pdm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic signed [DATA_W-1:0] x,
    output logic                     pdm_out,
    output logic signed [ACC_W-1:0]  i1,
    output logic signed [ACC_W-1:0]  i2
);

    localparam logic signed [63:0] FULL_SCALE = 64'sd1 <<< (DATA_W - 1);

    logic               y;
    logic signed [63:0] fb;
    logic signed [63:0] i1_nxt;
    logic signed [63:0] i2_nxt;

    // Quantiser decides from the second integrator before it updates; the
    // second integrator consumes the first integrator's old value.
    always_comb begin
        y      = ~i2[ACC_W-1];
        fb     = y ? FULL_SCALE : -FULL_SCALE;
        i1_nxt = sat_acc(64'(i1) + 64'(x) - fb, ACC_W);
        i2_nxt = sat_acc(64'(i2) + 64'(i1) - fb, ACC_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1      <= '0;
            i2      <= '0;
            pdm_out <= 1'b0;
        end else if (tick) begin
            i1      <= ACC_W'(i1_nxt);
            i2      <= ACC_W'(i2_nxt);
            pdm_out <= y;
        end
    end

endmodule

// File: rtl/pdm_sigma_delta_tx.sv
// pdm_sigma_delta_tx: PCM-to-PDM transmitter. Buffers one signed PCM sample
// over valid/ready, linearly interpolates between consecutive samples across
// OSR PDM bits, and modulates with a 2nd-order sigma-delta loop.
// Ports:
//   clk, rst    clock / asynchronous active-high reset
//   pcm_data    signed PCM sample (DATA_W)
//   pcm_valid   pcm_data valid
//   pcm_ready   one-entry buffer empty; sample taken on valid && ready
//   pdm_en      1-clk strobe, high on the cycle pdm_out has just updated
//   pdm_out     PDM bit (1 = +FS, 0 = -FS)
//   underflow   1-clk pulse when a frame ends with no buffered sample
module pdm_sigma_delta_tx
    import pdm_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OSR     = DEF_OSR,
    parameter int CLK_DIV = 1,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] pcm_data,
    input  logic                     pcm_valid,
    output logic                     pcm_ready,
    output logic                     pdm_en,
    output logic                     pdm_out,
    output logic                     underflow
);

    localparam int OSR_LOG2 = $clog2(OSR);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // prev*OSR + (cur-prev)*phase always lies between prev*OSR and cur*OSR.
    localparam int XA_W     = DATA_W + OSR_LOG2;

    logic [DIV_W-1:0]         div;
    logic                     tick;
    logic [OSR_LOG2-1:0]      phase;
    logic                     wrap;
    logic                     accept;
    logic signed [DATA_W-1:0] prev;
    logic signed [DATA_W-1:0] cur;
    logic signed [DATA_W-1:0] next;
    logic                     next_full;
    logic signed [DATA_W:0]   delta;
    logic signed [XA_W-1:0]   x_acc;
    logic signed [DATA_W-1:0] x;
    // Integrator taps are kept on wires so they can be probed in simulation.
    logic signed [ACC_W-1:0]  i1_unused;
    logic signed [ACC_W-1:0]  i2_unused;

    assign tick      = (div == DIV_W'(CLK_DIV - 1));
    assign wrap      = tick && (phase == OSR_LOG2'(OSR - 1));
    assign pcm_ready = ~next_full;
    assign accept    = pcm_valid && ~next_full;
    assign delta     = {cur[DATA_W-1], cur} - {prev[DATA_W-1], prev};
    assign x         = DATA_W'(x_acc >>> OSR_LOG2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            phase     <= '0;
            prev      <= '0;
            cur       <= '0;
            next      <= '0;
            next_full <= 1'b0;
            x_acc     <= '0;
            pdm_en    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pdm_en    <= tick;
            underflow <= 1'b0;
            div       <= tick ? '0 : div + 1'b1;

            // Accept and consume are exclusive: ready is low while full.
            if (accept) begin
                next      <= pcm_data;
                next_full <= 1'b1;
            end

            if (tick) begin
                if (wrap) begin
                    phase <= '0;
                    prev  <= cur;
                    // The outgoing cur becomes the new prev, so the
                    // interpolator restarts exactly at that value.
                    x_acc <= {cur, {OSR_LOG2{1'b0}}};
                    if (next_full) begin
                        cur       <= next;
                        next_full <= 1'b0;
                    end else begin
                        underflow <= 1'b1;
                    end
                end else begin
                    phase <= phase + 1'b1;
                    x_acc <= x_acc + XA_W'(delta);
                end
            end
        end
    end

    pdm_sd2_core #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .x       (x),
        .pdm_out (pdm_out),
        .i1      (i1_unused),
        .i2      (i2_unused)
    );

endmodule
